// File: rtl/updown_cnt_pkg.sv
// Shared types and constants for the up/down counter scheduler.
package updown_cnt_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Highest legal count of the shared modulo-12 counter.
    localparam int MOD_MAX_DEF = 11;

endpackage

// File: rtl/updown_cnt_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward.
// The pointer moves to just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          found;
    int            idx;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PW'(idx);
            end
        end
    end

    // Pointer update: the winner becomes lowest priority next time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance && found)
            ptr <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end

endmodule

// File: rtl/updown_cnt_scheduler.sv
// Shares one modulo counter between N_REQ requesters. A granted command
// drives the counter's reset/load/din/up_down pins until it completes;
// when no command runs, the counter reloads its own count (frozen).
module updown_cnt_scheduler
    import updown_cnt_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 4,
    parameter int MOD_MAX = MOD_MAX_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [CNT_W*N_REQ-1:0] req_arg,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic                   err,
    output logic                   busy,
    output logic                   cnt_reset,
    output logic                   cnt_load,
    output logic [CNT_W-1:0]       cnt_din,
    output logic                   cnt_up_down,
    input  logic [CNT_W-1:0]       cnt_count
);

    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] arg_q;
    logic [CNT_W-1:0] rem_q;

    logic [N_REQ-1:0] grant;
    logic             advance;
    op_e              sel_op;
    logic [CNT_W-1:0] sel_arg;
    logic             reject;
    logic             zero_step;

    assign advance = (state == S_IDLE) && (|req);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    // Pick the winner's op/arg; only sampled at grant time.
    always_comb begin
        sel_op  = OP_LOAD;
        sel_arg = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_op  = op_e'(req_op[2*i +: 2]);
                sel_arg = req_arg[CNT_W*i +: CNT_W];
            end
        end
        reject    = (sel_op == OP_LOAD) && (int'(sel_arg) > MOD_MAX);
        zero_step = ((sel_op == OP_UP) || (sel_op == OP_DOWN)) && (sel_arg == '0);
    end

    // Command FSM with registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_LOAD;
            arg_q <= '0;
            rem_q <= '0;
            gnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (|req) begin
                        gnt   <= grant;
                        op_q  <= sel_op;
                        arg_q <= sel_arg;
                        rem_q <= sel_arg;
                        busy  <= 1'b1;
                        if (reject || zero_step) begin
                            // Nothing to do to the counter: answer at once.
                            state <= S_RESP;
                            done  <= 1'b1;
                            err   <= reject;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if ((op_q == OP_UP) || (op_q == OP_DOWN)) begin
                        // One counter step per cycle, arg steps in total.
                        if (rem_q == CNT_W'(1)) begin
                            state <= S_RESP;
                            done  <= 1'b1;
                        end else begin
                            rem_q <= rem_q - CNT_W'(1);
                        end
                    end else begin
                        state <= S_RESP;
                        done  <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Counter pin decode; exactly one of reset/load/count is active.
    always_comb begin
        cnt_reset   = reset;
        cnt_load    = 1'b0;
        cnt_din     = cnt_count;
        cnt_up_down = 1'b0;
        if (!reset) begin
            if (state == S_EXEC) begin
                case (op_q)
                    OP_LOAD: begin
                        cnt_load = 1'b1;
                        cnt_din  = arg_q;
                    end
                    OP_CLEAR: cnt_reset = 1'b1;
                    default:  cnt_up_down = (op_q == OP_DOWN);
                endcase
            end else begin
                // Idle and response: reload own count to freeze the counter.
                cnt_load = 1'b1;
            end
        end
    end

endmodule
